// File: rtl/ddr_lane_dm_tx_seq.sv
// ddr_lane_dm_tx_seq
//   Write-side sequencer for the DDR4 PHY DM lanes.
//   - Write pipe: delays fabric write beats by the write latency and emits per-lane
//     1:8 serialiser data plus a 4-bit output enable with preamble/postamble shaping.
//   - Delay FSM: steps or loads one lane's output delay line, tracks every lane's
//     tap and aborts before a step would leave the legal tap range.
// Ports
//   fab_clk, arst_n          clock (rising edge), asynchronous active-low reset
//   wr_valid, wr_dm, wr_lat  write beat strobe, per-lane DM bits, write latency
//   tx_data, oe_data, odt_en per-lane serialiser data, per-lane OE, ODT enable
//   dly_req/load/lane/dir/steps  delay operation request and its arguments
//   dly_busy, dly_done, dly_err  operation status (err sticky until next accept)
//   delay_line_move/direction/load/out_of_range  per-lane delay line interface
//   tap_pos                  tracked tap per lane, lane l at [TAP_W*l +: TAP_W]
//
// Delay FSM states
//   state   | meaning
//   S_IDLE  | waiting for a request
//   S_LOAD  | load pulse on addressed lane, tap restored to TAP_INIT
//   S_SETUP | direction driven one cycle ahead of the first move
//   S_MOVE  | one-cycle move pulse, tap tracked +/-1
//   S_GAP   | GAP_CYC settle cycles between moves, range flag watched
//   S_DONE  | one-cycle done pulse; a new request may be accepted here
module ddr_lane_dm_tx_seq #(
  parameter int NUM_LANES = 2,
  parameter int TAP_W     = 7,
  parameter int TAP_MAX   = 127,
  parameter int TAP_INIT  = 1,
  parameter int WL_MAX    = 15,
  parameter int GAP_CYC   = 3,
  localparam int LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                       fab_clk,
  input  logic                       arst_n,
  input  logic                       wr_valid,
  input  logic [8*NUM_LANES-1:0]     wr_dm,
  input  logic [3:0]                 wr_lat,
  output logic [8*NUM_LANES-1:0]     tx_data,
  output logic [4*NUM_LANES-1:0]     oe_data,
  output logic                       odt_en,
  input  logic                       dly_req,
  input  logic                       dly_load,
  input  logic [LANE_W-1:0]          dly_lane,
  input  logic                       dly_dir,
  input  logic [TAP_W-1:0]           dly_steps,
  output logic                       dly_busy,
  output logic                       dly_done,
  output logic                       dly_err,
  output logic [NUM_LANES-1:0]       delay_line_move,
  output logic [NUM_LANES-1:0]       delay_line_direction,
  output logic [NUM_LANES-1:0]       delay_line_load,
  input  logic [NUM_LANES-1:0]       delay_line_out_of_range,
  output logic [TAP_W*NUM_LANES-1:0] tap_pos
);

  localparam int DM_W  = 8 * NUM_LANES;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [3:0]       WL_CAP     = 4'(WL_MAX);
  localparam logic [TAP_W-1:0] TAP_MAX_V  = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0] TAP_INIT_V = TAP_W'(TAP_INIT);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYC - 1);

  // ---------------- write pipe ----------------
  // stg[k] is the beat that entered k cycles ago; stg[0] is the live input.
  logic [WL_MAX-1:0] pipe_vld;
  logic [DM_W-1:0]   pipe_dm [WL_MAX];
  logic [WL_MAX:0]   stg_vld;
  logic [DM_W-1:0]   stg_dm [WL_MAX+1];
  logic [3:0]        wl_q, wl_new;
  logic              cur_vld, nxt_vld, tx_vld_q, pre_now;
  logic [3:0]        oe_q, oe_lane;

  assign wl_new = (wr_lat > WL_CAP) ? WL_CAP : wr_lat;

  always_comb begin
    stg_vld[0] = wr_valid;
    stg_dm[0]  = wr_dm;
    for (int k = 1; k <= WL_MAX; k++) begin
      stg_vld[k] = pipe_vld[k-1];
      stg_dm[k]  = pipe_dm[k-1];
    end
  end

  assign cur_vld = stg_vld[wl_q];
  // lookahead one stage younger: that beat reaches the output one cycle later
  assign nxt_vld = (wl_q != 4'd0) && stg_vld[wl_q - 4'd1];

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      pipe_vld <= '0;
      for (int k = 0; k < WL_MAX; k++) pipe_dm[k] <= '0;
      wl_q     <= '0;
      tx_vld_q <= 1'b0;
      tx_data  <= '0;
      oe_q     <= '0;
    end else begin
      pipe_vld <= stg_vld[WL_MAX-1:0];
      for (int k = 0; k < WL_MAX; k++) pipe_dm[k] <= stg_dm[k];
      // latency only changes while nothing is in flight, so no beat is lost or doubled
      if (pipe_vld == '0 && !wr_valid) wl_q <= wl_new;
      tx_vld_q <= cur_vld;
      tx_data  <= cur_vld ? stg_dm[wl_q] : '0;
      oe_q     <= cur_vld ? 4'b1111 : {nxt_vld, 2'b00, tx_vld_q};
    end
  end

  // At zero latency the preamble cycle is the cycle the beat is presented, so it
  // cannot come from a register; it is taken straight from the input strobe.
  assign pre_now = (wl_q == 4'd0) && wr_valid;
  assign oe_lane = oe_q | {pre_now, 3'b000};
  assign oe_data = {NUM_LANES{oe_lane}};
  assign odt_en  = |oe_lane;

  // ---------------- delay FSM ----------------
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_DONE} state_t;
  state_t state_q, state_d;

  logic [LANE_W-1:0]    lane_q;
  logic                 dir_q, err_q, accept, abort, can_move, gap_tc;
  logic [NUM_LANES-1:0] dir_line_q;
  logic [TAP_W-1:0]     steps_q, tap_cur;
  logic [GAP_W-1:0]     gap_q;
  logic [TAP_W-1:0]     tap_q [NUM_LANES];

  assign accept   = dly_req && (state_q == S_IDLE || state_q == S_DONE);
  assign tap_cur  = tap_q[lane_q];
  assign can_move = dir_q ? (tap_cur != TAP_MAX_V) : (tap_cur != '0);
  assign gap_tc   = (gap_q == '0);

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (dly_req) begin
          if (dly_load)              state_d = S_LOAD;
          else if (dly_steps == '0)  state_d = S_DONE;
          else                       state_d = S_SETUP;
        end
      end
      S_LOAD:  state_d = S_DONE;
      S_SETUP: begin
        if (can_move) state_d = S_MOVE;
        else begin state_d = S_DONE; abort = 1'b1; end
      end
      S_MOVE:  state_d = S_GAP;
      S_GAP: begin
        if (delay_line_out_of_range[lane_q]) begin
          state_d = S_DONE; abort = 1'b1;
        end else if (gap_tc) begin
          if (steps_q == '0)  state_d = S_DONE;
          else if (can_move)  state_d = S_MOVE;
          else begin state_d = S_DONE; abort = 1'b1; end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dly_busy        = 1'b0;
    dly_done        = 1'b0;
    delay_line_move = '0;
    delay_line_load = '0;
    case (state_q)
      S_LOAD:         begin dly_busy = 1'b1; delay_line_load[lane_q] = 1'b1; end
      S_SETUP, S_GAP: dly_busy = 1'b1;
      S_MOVE:         begin dly_busy = 1'b1; delay_line_move[lane_q] = 1'b1; end
      S_DONE:         dly_done = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      lane_q     <= '0;
      dir_q      <= 1'b0;
      dir_line_q <= '0;
      steps_q    <= '0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) tap_q[l] <= TAP_INIT_V;
    end else begin
      if (accept) begin
        lane_q  <= dly_lane;
        dir_q   <= dly_dir;
        steps_q <= dly_steps;
        err_q   <= 1'b0;
        if (!dly_load && dly_steps != '0) dir_line_q[dly_lane] <= dly_dir;
      end
      if (abort) err_q <= 1'b1;
      if (state_q == S_MOVE) begin
        tap_q[lane_q] <= dir_q ? tap_cur + TAP_W'(1) : tap_cur - TAP_W'(1);
        steps_q       <= steps_q - TAP_W'(1);
        gap_q         <= GAP_LOAD;
      end else if (state_q == S_GAP && !gap_tc) begin
        gap_q <= gap_q - GAP_W'(1);
      end
      if (state_q == S_LOAD) tap_q[lane_q] <= TAP_INIT_V;
    end
  end

  assign dly_err              = err_q;
  assign delay_line_direction = dir_line_q;

  always_comb begin
    tap_pos = '0;
    for (int l = 0; l < NUM_LANES; l++) tap_pos[l*TAP_W +: TAP_W] = tap_q[l];
  end

endmodule
